// File: rtl/adc_rd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | adc_rd_pkg : shared state encoding and default sizes for adc_readout  |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
package adc_rd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    READ    = 2'd3
  } adc_state_t;

  localparam int ADC_DATA_W    = 8;
  localparam int ADC_RD_CYCLES = 3;
  localparam int ADC_TIMEOUT   = 63;

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bit_sync : STAGES-deep single-bit synchronizer, async reset to 0      |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/adc_readout.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | adc_readout : BUSY-handshake parallel ADC reader with CS/RD strobes   |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module adc_readout
  import adc_rd_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int RD_CYCLES   = ADC_RD_CYCLES,
  parameter int TIMEOUT     = ADC_TIMEOUT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              convst_bar,
  input  logic              adc_busy,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_cs_n,
  output logic              adc_rd_n,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int TW = $clog2(TIMEOUT + 1);

  adc_state_t  r_state;
  adc_state_t  w_state_nxt;
  logic        r_convst_q;
  logic [TW-1:0] r_tcnt;
  logic [TW-1:0] w_tcnt_nxt;
  logic [3:0]  r_rcnt;
  logic [3:0]  w_rcnt_nxt;
  logic        w_busy_s;
  logic        w_start;
  logic        w_done;
  logic        w_timeout;
  logic        w_overrun;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_busy_sync (
    .clk(clk),
    .rst(rst),
    .d  (adc_busy),
    .q  (w_busy_s)
  );

  assign w_start = !convst_bar && r_convst_q;

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_rcnt_nxt  = r_rcnt;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    // A start seen anywhere but IDLE, including READ's final cycle, is dropped.
    w_overrun   = w_start && (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = WAIT_HI;
          w_tcnt_nxt  = '0;
        end
      end
      WAIT_HI: begin
        if (w_busy_s) begin
          w_state_nxt = WAIT_LO;
          w_tcnt_nxt  = '0;
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_state_nxt = IDLE;
          w_timeout   = 1'b1;
        end else begin
          w_tcnt_nxt  = r_tcnt + TW'(1);
        end
      end
      WAIT_LO: begin
        if (!w_busy_s) begin
          w_state_nxt = READ;
          w_rcnt_nxt  = '0;
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_state_nxt = IDLE;
          w_timeout   = 1'b1;
        end else begin
          w_tcnt_nxt  = r_tcnt + TW'(1);
        end
      end
      READ: begin
        if (r_rcnt == 4'(RD_CYCLES - 1)) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end else begin
          w_rcnt_nxt  = r_rcnt + 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // CS/RD decode from the next state so the strobes are glitch-free flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_convst_q   <= 1'b1;
      r_tcnt       <= '0;
      r_rcnt       <= '0;
      adc_cs_n     <= 1'b1;
      adc_rd_n     <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_convst_q   <= convst_bar;
      r_tcnt       <= w_tcnt_nxt;
      r_rcnt       <= w_rcnt_nxt;
      adc_cs_n     <= (w_state_nxt != READ);
      adc_rd_n     <= (w_state_nxt != READ);
      if (w_done) begin
        sample <= adc_data;
      end
      sample_valid <= w_done;
      timeout_err  <= w_timeout;
      overrun      <= w_overrun;
    end
  end

endmodule
`default_nettype wire

// File: doc/adc_readout.md
# adc_readout

Parallel-ADC read controller for the digitally controlled buck loop. It consumes the `convst_bar` conversion-start strobe from the clock divider and waits for the external ADC's BUSY handshake. It then drives CS/RD to read the converted word and hands one registered sample per conversion to the compensator with a single-cycle valid pulse. It also reports a conversion timeout and any overrun (a start strobe arriving while a read is still in progress).

## Interface
Parameters:
- `DATA_W`, 8, ADC word width
- `RD_CYCLES`, 3, clock periods CS/RD held low; legal range 1..15
- `TIMEOUT`, 63, maximum cycles spent waiting for BUSY edges; legal range 2..255
- `SYNC_STAGES`, 2, flip-flop stages on `adc_busy`; legal values 2..3

Ports:
- `clk` in 1: system clock, same domain as `convst_bar`
- `rst` in 1: asynchronous, active-high reset
- `convst_bar` in 1: conversion start, active low, synchronous to `clk`
- `adc_busy` in 1: ADC BUSY, asynchronous, high while converting
- `adc_data` in DATA_W: ADC parallel output, valid while `adc_rd_n` is low
- `adc_cs_n` out 1: ADC chip select, active low, registered
- `adc_rd_n` out 1: ADC read strobe, active low, registered
- `sample` out DATA_W: last successfully read word
- `sample_valid` out 1: one-cycle pulse when `sample` updates
- `timeout_err` out 1: one-cycle pulse when a BUSY wait times out
- `overrun` out 1: one-cycle pulse when a start edge is seen outside IDLE

## Operation
- Start event: `convst_bar` is 0 while the registered previous value `convst_q` is 1. `convst_q` resets to 1.
- `adc_busy` passes through a SYNC_STAGES-deep synchronizer (reset to 0) to form `busy_s`. Only `busy_s` is used.
- FSM states: IDLE, WAIT_HI, WAIT_LO, READ.
  - IDLE: on a start event, go to WAIT_HI and clear the timeout counter `tcnt`.
  - WAIT_HI: if `busy_s`=1, go to WAIT_LO and clear `tcnt`. Otherwise increment `tcnt`.
  - WAIT_LO: if `busy_s`=0, go to READ and clear the read counter `rcnt`. Otherwise increment `tcnt`.
  - In WAIT_HI or WAIT_LO, when `tcnt`=TIMEOUT-1 and the exit condition is false: pulse `timeout_err`, go to IDLE, leave `sample` unchanged.
  - READ: `rcnt` increments. At `rcnt`=RD_CYCLES-1, register `sample` from `adc_data`, pulse `sample_valid`, and go to IDLE.
- `adc_cs_n` and `adc_rd_n` are both 0 exactly while the state is READ (registered decode, no glitches). They are 1 otherwise.
- A start event in any state other than IDLE is ignored and pulses `overrun`. The current transaction continues undisturbed.
- A start event on the same edge that READ returns to IDLE counts as an overrun. It is not accepted.
- `tcnt` width is clog2(TIMEOUT+1). `rcnt` width is 4. Neither counter wraps, because each is cleared on every state entry.

## Timing
- Reset values: state IDLE, `adc_cs_n`=1, `adc_rd_n`=1, `sample`=0, `sample_valid`=0, `timeout_err`=0, `overrun`=0, synchronizer flops 0.
- Reset asserted mid-transaction aborts it immediately and asynchronously. CS/RD go high and no `sample_valid` is produced.
- The state leaves IDLE on the first edge where the start event is true.
- BUSY edges appear on `busy_s` SYNC_STAGES edges after they are sampled.
- READ is entered on the first edge where WAIT_LO sees `busy_s`=0.
- CS/RD are low for exactly RD_CYCLES clock periods.
- `sample` and `sample_valid` update on the edge that returns the FSM to IDLE. `sample_valid` is high for the cycle in which CS/RD are back high.
- `timeout_err` and `overrun` are registered and high for one cycle.
- Minimum start-to-start spacing without overrun: 2 + (BUSY high time) + SYNC_STAGES + RD_CYCLES cycles. The clock divider's 64-cycle period satisfies this for BUSY shorter than 50 cycles at default parameters.

## Structure
- Package `adc_rd_pkg` holds:
  - the state enum (IDLE, WAIT_HI, WAIT_LO, READ)
  - default constants `ADC_DATA_W`=8, `ADC_RD_CYCLES`=3, `ADC_TIMEOUT`=63
- One sub-module, `bit_sync`: parameterized-depth, async-reset, single-bit synchronizer, instantiated for `adc_busy`.
- The FSM, counters and output registers live in `adc_readout`.

## Test plan
- Nominal read: after reset, `convst_bar` pulses low. A BUSY model goes high 2 cycles later for 10 cycles with `adc_data`=8'hA5.
  - Required: CS/RD low for 3 cycles, starting SYNC_STAGES+1 cycles after BUSY falls.
  - Required: `sample`=8'hA5 and `sample_valid` high for 1 cycle; `timeout_err` and `overrun` stay 0.
- BUSY never rises: `convst_bar` pulses and `adc_busy` is held 0. Required: `timeout_err` pulses once 63 cycles after WAIT_HI entry, CS/RD stay high, `sample` is unchanged.
- BUSY stuck high: BUSY rises and never falls. Required: `timeout_err` pulses 63 cycles after WAIT_LO entry, then FSM returns to IDLE. A following normal conversion with data 8'h3C yields `sample`=8'h3C.
- Overrun: a second `convst_bar` falling edge arrives while in WAIT_LO. Required: `overrun` pulses once, and the first transaction completes with its own data (8'h11).
- Reset mid-read: assert `rst` during the 2nd READ cycle. Required: CS/RD go to 1 without waiting for a clock edge, `sample`=0, no `sample_valid`. A clean read succeeds after reset is released.
- Back-to-back: run 4 conversions with the divider's 64-cycle period and data 8'h00, 8'hFF, 8'h80, 8'h7F. Required: exactly 4 `sample_valid` pulses with matching values and no overrun.
